multdiv_seq: RTL
================

MULTDIV_SEQ -- requirements
Module: multdiv_seq

Interface
REQ-001 SHALL have port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port data_operandA, input, 32 bits: signed two's-complement multiplicand or dividend.
REQ-004 SHALL have port data_operandB, input, 32 bits: signed two's-complement multiplier or divisor.
REQ-005 SHALL have port ctrl_MULT, input, 1 bit: start pulse for multiply.
REQ-006 SHALL have port ctrl_DIV, input, 1 bit: start pulse for divide.
REQ-007 SHALL have port data_result, output, 32 bits: result of the last completed operation.
REQ-008 SHALL have port data_exception, output, 1 bit: exception flag of the last completed operation.
REQ-009 SHALL have port data_resultRDY, output, 1 bit: one-cycle completion strobe.

Function
REQ-010 SHALL have states IDLE, MULT, DIV and DONE.
REQ-011 SHALL, on an edge with ctrl_MULT=1, latch both operands, clear the iteration counter and enter MULT, from any state.
REQ-012 SHALL, on an edge with ctrl_DIV=1 and ctrl_MULT=0, latch both operands, clear the counter and enter DIV, from any state.
REQ-013 SHALL treat ctrl_MULT=ctrl_DIV=1 as a multiply start.
REQ-014 SHALL restart on a start pulse received while in MULT or DIV: the old operation is discarded and produces no RDY strobe.
REQ-015 SHALL ignore operand changes after the start edge; latched copies only.
REQ-016 SHALL multiply with radix-4 modified Booth recoding.
- 16 iterations, one per clock.
- 65-bit product/multiplier shift register.
- Sign-extended partial products of +-0/1/2 x A.
REQ-017 SHALL divide with non-restoring division on operand magnitudes.
- 32 iterations, one per clock.
- Quotient sign = signA XOR signB.
- Truncation toward zero; remainder discarded.
REQ-018 SHALL move MULT->DONE on the 16th iteration edge and DIV->DONE on the 32nd iteration edge, then DONE->IDLE on the next edge.
REQ-019 SHALL hold data_resultRDY=1 for exactly the one cycle spent in DONE.
- Multiply: RDY high in the cycle after start edge E0+17.
- Divide: RDY high in the cycle after start edge E0+33.
REQ-020 SHALL set data_result to the low 32 bits of the 64-bit product for a multiply.
REQ-021 SHALL assert data_exception on a multiply when product bits [63:31] are not all equal (signed overflow).
REQ-022 SHALL, for divide by zero, return data_result=0 and data_exception=1.
REQ-023 SHALL, for 0x80000000 / 0xFFFFFFFF, return data_result=0x80000000 and data_exception=1.
REQ-024 SHALL otherwise give data_exception=0 on a divide.
REQ-025 SHALL hold data_result and data_exception from the last completion until the next DONE or reset; a start pulse does not clear them.
REQ-026 SHALL honour a start pulse in DONE: RDY is still high in that cycle, and the next state is MULT/DIV.

Reset
REQ-027 SHALL, while reset=1, immediately force:
- state to IDLE;
- counter to 0;
- data_result to 0x00000000;
- data_exception to 0;
- data_resultRDY to 0.
REQ-028 SHALL abort any in-flight operation on reset, with no RDY strobe afterward.
REQ-029 SHALL ignore start pulses while reset=1.

Verification
REQ-030 Bench SHALL cover multiply A=7, B=-3 (0xFFFFFFFD) -> RDY one cycle after E0+17, result 0xFFFFFFEB, exception 0.
REQ-031 Bench SHALL cover multiply 0x00010000 x 0x00010000 -> result 0x00000000, exception 1. Also 0x80000000 x 0x00000001 -> result 0x80000000, exception 0.
REQ-032 Bench SHALL cover divide -7 / 2 -> RDY one cycle after E0+33, result 0xFFFFFFFD, exception 0. Also 100 / -7 -> 0xFFFFFFF2.
REQ-033 Bench SHALL cover divide 5 / 0 -> result 0, exception 1. Also 0x80000000 / 0xFFFFFFFF -> result 0x80000000, exception 1.
REQ-034 Bench SHALL cover ctrl_DIV 12/4 then ctrl_MULT 3x5 at E0+10 -> single RDY one cycle after restart+17, result 15, no strobe for the divide.
REQ-035 Bench SHALL cover reset asserted mid-multiply between clock edges -> outputs 0 immediately, no RDY afterward. A new 6x7 start after release -> result 42.

Source files
------------

// File: rtl/multdiv_seq.sv
// Sequential signed 32-bit multiplier (radix-4 Booth, 16 steps) and divider
// (non-restoring on magnitudes, 32 steps) sharing one control FSM.
module multdiv_seq (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY
);

  localparam int unsigned W          = 32;
  localparam int unsigned PW         = 2 * W + 1;
  localparam int unsigned AW         = W + 2;
  localparam int unsigned CW         = 6;
  localparam int unsigned MULT_ITERS = 16;
  localparam int unsigned DIV_ITERS  = 32;

  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic [PW-1:0]  prod;
  logic [AW-1:0]  rem;
  logic [W-1:0]   quo;
  logic [W-1:0]   den;

  logic [AW-1:0]  a_ext;
  logic [AW-1:0]  pp;
  logic [AW-1:0]  acc;
  logic [PW-1:0]  prod_next;
  logic           mul_ovf;
  logic [W-1:0]   abs_a;
  logic [W-1:0]   abs_b;
  logic [AW-1:0]  rem_sh;
  logic [AW-1:0]  rem_next;
  logic [W-1:0]   quo_next;
  logic [W-1:0]   quo_signed;
  logic           div_zero;
  logic           div_ovf;

  // Booth step: add the recoded partial product to the 34-bit upper slice, then shift by two
  always_comb begin
    a_ext = {{2{op_a[W-1]}}, op_a};
    pp    = '0;
    case (prod[2:0])
      3'b001, 3'b010: pp = a_ext;
      3'b011:         pp = {a_ext[AW-2:0], 1'b0};
      3'b100:         pp = ~{a_ext[AW-2:0], 1'b0} + AW'(1);
      3'b101, 3'b110: pp = ~a_ext + AW'(1);
      default:        pp = '0;
    endcase
    acc       = {{2{prod[PW-1]}}, prod[PW-1:W+1]} + pp;
    prod_next = {acc, prod[W:2]};
    mul_ovf   = !((&prod_next[PW-1:W]) || !(|prod_next[PW-1:W]));
  end

  // Non-restoring step; quotient bits are final, only the remainder would need fixing
  always_comb begin
    abs_a      = op_a[W-1] ? (~op_a + W'(1)) : op_a;
    abs_b      = op_b[W-1] ? (~op_b + W'(1)) : op_b;
    rem_sh     = {rem[AW-2:0], quo[W-1]};
    rem_next   = rem[AW-1] ? (rem_sh + {2'b00, den}) : (rem_sh - {2'b00, den});
    quo_next   = {quo[W-2:0], ~rem_next[AW-1]};
    quo_signed = (op_a[W-1] ^ op_b[W-1]) ? (~quo_next + W'(1)) : quo_next;
    div_zero   = (op_b == '0);
    div_ovf    = (op_a == {1'b1, {(W-1){1'b0}}}) && (op_b == '1);
  end

  // Control FSM; the first edge in MULT/DIV loads the working registers from the latched operands
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      op_a           <= '0;
      op_b           <= '0;
      prod           <= '0;
      rem            <= '0;
      quo            <= '0;
      den            <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (ctrl_MULT) begin
        op_a  <= data_operandA;
        op_b  <= data_operandB;
        cnt   <= '0;
        state <= MULT;
      end else if (ctrl_DIV) begin
        op_a  <= data_operandA;
        op_b  <= data_operandB;
        cnt   <= '0;
        state <= DIV;
      end else begin
        case (state)
          MULT: begin
            cnt <= cnt + CW'(1);
            if (cnt == '0) begin
              prod <= {{W{1'b0}}, op_b, 1'b0};
            end else begin
              prod <= prod_next;
              if (cnt == CW'(MULT_ITERS)) begin
                data_result    <= prod_next[W:1];
                data_exception <= mul_ovf;
                data_resultRDY <= 1'b1;
                state          <= DONE;
              end
            end
          end
          DIV: begin
            cnt <= cnt + CW'(1);
            if (cnt == '0) begin
              rem <= '0;
              quo <= abs_a;
              den <= abs_b;
            end else begin
              rem <= rem_next;
              quo <= quo_next;
              if (cnt == CW'(DIV_ITERS)) begin
                data_result    <= div_zero ? '0 : quo_signed;
                data_exception <= div_zero || div_ovf;
                data_resultRDY <= 1'b1;
                state          <= DONE;
              end
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
